// File: rtl/program_counter_pkg.sv
// Shared opcode encodings and stack-command type for the program counter and decode stage.
package program_counter_pkg;

  localparam int OP_WIDTH = 3;

  typedef logic [OP_WIDTH-1:0] opcode_t;

  localparam opcode_t OP_HOLD   = 3'b000;
  localparam opcode_t OP_INC    = 3'b001;
  localparam opcode_t OP_JUMP   = 3'b010;
  localparam opcode_t OP_BRANCH = 3'b011;
  localparam opcode_t OP_CALL   = 3'b100;
  localparam opcode_t OP_RETURN = 3'b101;
  localparam opcode_t OP_RELOAD = 3'b110;
  localparam opcode_t OP_RSVD   = 3'b111;

  typedef enum logic [1:0] {
    STK_NONE  = 2'b00,
    STK_PUSH  = 2'b01,
    STK_POP   = 2'b10,
    STK_FLUSH = 2'b11
  } stack_cmd_e;

endpackage

// File: rtl/pc_return_stack.sv
// LIFO return-address stack; the pointer counts entries held (0..STACK_DEPTH).
module pc_return_stack #(
  parameter int ADDR_WIDTH  = 16,
  parameter int STACK_DEPTH = 8
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  flush,
  input  logic [ADDR_WIDTH-1:0] push_data,
  output logic [ADDR_WIDTH-1:0] top,
  output logic                  empty,
  output logic                  full
);

  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam int PTR_W = IDX_W + 1;

  logic [PTR_W-1:0]      ptr;
  logic [ADDR_WIDTH-1:0] mem [STACK_DEPTH];
  logic [IDX_W-1:0]      top_idx;
  logic                  do_push;
  logic                  do_pop;

  assign empty   = (ptr == '0);
  assign full    = (ptr == PTR_W'(STACK_DEPTH));
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush && !push;

  // With a power-of-two depth the wrapped index of ptr-1 is the top entry even when full
  assign top_idx = ptr[IDX_W-1:0] - IDX_W'(1);
  assign top     = mem[top_idx];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ptr <= '0;
    end else if (flush) begin
      ptr <= '0;
    end else if (do_push) begin
      ptr <= ptr + PTR_W'(1);
    end else if (do_pop) begin
      ptr <= ptr - PTR_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[ptr[IDX_W-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/program_counter_stack.sv
// Fetch-address generator: next-PC selection, PC register, and call/return stack error reporting.
module program_counter_stack
  import program_counter_pkg::*;
#(
  parameter int                    ADDR_WIDTH   = 16,
  parameter int                    STACK_DEPTH  = 8,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic [OP_WIDTH-1:0]   opcode,
  input  logic [ADDR_WIDTH-1:0] target,
  input  logic [ADDR_WIDTH-1:0] offset,
  input  logic                  cond,
  output logic [ADDR_WIDTH-1:0] pc_out,
  output logic                  stack_empty,
  output logic                  stack_full,
  output logic                  stack_err
);

  logic [ADDR_WIDTH-1:0] pc_reg;
  logic [ADDR_WIDTH-1:0] pc_next;
  logic [ADDR_WIDTH-1:0] pc_inc;
  logic [ADDR_WIDTH-1:0] pc_rel;
  logic [ADDR_WIDTH-1:0] stk_top;
  logic                  stk_empty;
  logic                  stk_full;
  logic                  err_reg;
  logic                  err_next;
  stack_cmd_e            stk_cmd;

  assign pc_inc = pc_reg + ADDR_WIDTH'(1);
  assign pc_rel = pc_reg + offset;

  pc_return_stack #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_stack (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (stk_cmd == STK_PUSH),
    .pop       (stk_cmd == STK_POP),
    .flush     (stk_cmd == STK_FLUSH),
    .push_data (pc_inc),
    .top       (stk_top),
    .empty     (stk_empty),
    .full      (stk_full)
  );

  // Rejected CALL/RETURN leave both the PC and the stack untouched and only raise the error
  always_comb begin
    pc_next  = pc_reg;
    err_next = 1'b0;
    stk_cmd  = STK_NONE;
    if (enable) begin
      case (opcode)
        OP_INC:    pc_next = pc_inc;
        OP_JUMP:   pc_next = target;
        OP_BRANCH: pc_next = cond ? pc_rel : pc_inc;
        OP_CALL: begin
          if (stk_full) begin
            err_next = 1'b1;
          end else begin
            stk_cmd = STK_PUSH;
            pc_next = target;
          end
        end
        OP_RETURN: begin
          if (stk_empty) begin
            err_next = 1'b1;
          end else begin
            stk_cmd = STK_POP;
            pc_next = stk_top;
          end
        end
        OP_RELOAD: begin
          stk_cmd = STK_FLUSH;
          pc_next = RESET_VECTOR;
        end
        default: pc_next = pc_reg;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc_reg  <= RESET_VECTOR;
      err_reg <= 1'b0;
    end else begin
      pc_reg  <= pc_next;
      err_reg <= err_next;
    end
  end

  assign pc_out      = pc_reg;
  assign stack_empty = stk_empty;
  assign stack_full  = stk_full;
  assign stack_err   = err_reg;

endmodule

// File: tb/tb_program_counter_stack.sv
// Randomized and directed bench for program_counter_stack against a queue-based reference model.
module tb_program_counter_stack;
  import program_counter_pkg::*;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        rst16_n, en16, cond16;
  logic [2:0]  op16;
  logic [15:0] tgt16, off16, pc16;
  logic        empty16, full16, err16;

  logic        rst12_n, en12, cond12;
  logic [2:0]  op12;
  logic [11:0] tgt12, off12, pc12;
  logic        empty12, full12, err12;

  int checks = 0;
  int failures = 0;

  int unsigned pc_m [2];
  bit          err_m [2];
  int unsigned stk16 [$];
  int unsigned stk12 [$];

  program_counter_stack #(.ADDR_WIDTH(16), .STACK_DEPTH(8), .RESET_VECTOR(16'h0000)) dut16 (
    .clock(clock), .reset_n(rst16_n), .enable(en16), .opcode(op16), .target(tgt16),
    .offset(off16), .cond(cond16), .pc_out(pc16), .stack_empty(empty16),
    .stack_full(full16), .stack_err(err16)
  );

  program_counter_stack #(.ADDR_WIDTH(12), .STACK_DEPTH(8), .RESET_VECTOR(12'h010)) dut12 (
    .clock(clock), .reset_n(rst12_n), .enable(en12), .opcode(op12), .target(tgt12),
    .offset(off12), .cond(cond12), .pc_out(pc12), .stack_empty(empty12),
    .stack_full(full12), .stack_err(err12)
  );

  function automatic int unsigned mask_of(int i);
    return (i == 0) ? 32'h0000_FFFF : 32'h0000_0FFF;
  endfunction

  function automatic int unsigned vector_of(int i);
    return (i == 0) ? 32'h0 : 32'h10;
  endfunction

  function automatic int qsize(int i);
    return (i == 0) ? stk16.size() : stk12.size();
  endfunction

  // Packed {pc, empty, full, err}; the 12-bit instance is zero-extended
  function automatic logic [18:0] observed(int i);
    return (i == 0) ? {pc16, empty16, full16, err16} : {4'h0, pc12, empty12, full12, err12};
  endfunction

  function automatic logic [18:0] expected(int i);
    int unsigned p = pc_m[i];
    return {p[15:0], qsize(i) == 0, qsize(i) == 8, err_m[i]};
  endfunction

  task automatic model_reset(int i);
    pc_m[i]  = vector_of(i);
    err_m[i] = 1'b0;
    if (i == 0) stk16.delete(); else stk12.delete();
  endtask

  task automatic model_step(int i, logic [2:0] op, int unsigned tgt, int unsigned off, bit c, bit en);
    int unsigned m = mask_of(i);
    err_m[i] = 1'b0;
    if (!en) return;
    case (op)
      3'd1: pc_m[i] = (pc_m[i] + 1) & m;
      3'd2: pc_m[i] = tgt & m;
      3'd3: pc_m[i] = c ? ((pc_m[i] + off) & m) : ((pc_m[i] + 1) & m);
      3'd4: begin
        if (qsize(i) == 8) err_m[i] = 1'b1;
        else begin
          if (i == 0) stk16.push_back((pc_m[i] + 1) & m);
          else        stk12.push_back((pc_m[i] + 1) & m);
          pc_m[i] = tgt & m;
        end
      end
      3'd5: begin
        if (qsize(i) == 0) err_m[i] = 1'b1;
        else pc_m[i] = (i == 0) ? stk16.pop_back() : stk12.pop_back();
      end
      3'd6: begin
        pc_m[i] = vector_of(i);
        if (i == 0) stk16.delete(); else stk12.delete();
      end
      default: ;
    endcase
  endtask

  // Drive one operation, let it be sampled at the next rising edge, then advance the model
  task automatic drive(int i, logic [2:0] op, int unsigned tgt, int unsigned off, bit c, bit en);
    if (i == 0) begin
      op16 = op; tgt16 = tgt[15:0]; off16 = off[15:0]; cond16 = c; en16 = en;
    end else begin
      op12 = op; tgt12 = tgt[11:0]; off12 = off[11:0]; cond12 = c; en12 = en;
    end
    @(posedge clock);
    #1;
    model_step(i, op, tgt, off, c, en);
  endtask

  task automatic async_reset(int i);
    @(posedge clock);
    #3;
    if (i == 0) rst16_n = 1'b0; else rst12_n = 1'b0;
    #1;
    model_reset(i);
  endtask

  task automatic release_reset(int i);
    if (i == 0) rst16_n = 1'b1; else rst12_n = 1'b1;
  endtask

  task automatic test_reset;
    drive(0, OP_JUMP, 16'h5A5A, 0, 0, 1);
    async_reset(0);
    checks++;
    if (observed(0) !== {16'h0000, 1'b1, 1'b0, 1'b0}) begin
      failures++;
      $display("[TB] FAIL reset16: got %h want %h", observed(0), {16'h0000, 3'b100});
    end
    release_reset(0);
    async_reset(1);
    checks++;
    if (observed(1) !== {4'h0, 12'h010, 1'b1, 1'b0, 1'b0}) begin
      failures++;
      $display("[TB] FAIL reset12: got %h want %h", observed(1), {16'h0010, 3'b100});
    end
    release_reset(1);
  endtask

  task automatic test_inc_wrap;
    drive(0, OP_JUMP, 16'hFFFE, 0, 0, 1);
    for (int k = 0; k < 3; k++) begin
      if (k > 0) drive(0, OP_INC, 0, 0, 0, 1);
      checks++;
      if (observed(0) !== expected(0)) begin
        failures++;
        $display("[TB] FAIL inc_wrap step %0d: got %h want %h", k, observed(0), expected(0));
      end
    end
    checks++;
    if (pc16 !== 16'h0000) begin
      failures++;
      $display("[TB] FAIL inc_wrap_zero: got %h want 0000", pc16);
    end
  endtask

  task automatic test_branch;
    drive(0, OP_JUMP, 16'h0040, 0, 0, 1);
    drive(0, OP_BRANCH, 16'h9999, 16'hFFF0, 1, 1);
    checks++;
    if (pc16 !== 16'h0030 || observed(0) !== expected(0)) begin
      failures++;
      $display("[TB] FAIL branch_taken: got %h want 0030", pc16);
    end
    drive(0, OP_JUMP, 16'h0040, 0, 0, 1);
    drive(0, OP_BRANCH, 16'h9999, 16'hFFF0, 0, 1);
    checks++;
    if (pc16 !== 16'h0041 || observed(0) !== expected(0)) begin
      failures++;
      $display("[TB] FAIL branch_not_taken: got %h want 0041", pc16);
    end
  endtask

  task automatic test_call_return;
    logic [15:0] want [4] = '{16'h0200, 16'h0300, 16'h0201, 16'h0101};
    logic [2:0]  ops  [4] = '{OP_CALL, OP_CALL, OP_RETURN, OP_RETURN};
    int unsigned tgts [4] = '{32'h200, 32'h300, 32'h0, 32'h0};
    drive(0, OP_JUMP, 16'h0100, 0, 0, 1);
    for (int k = 0; k < 4; k++) begin
      drive(0, ops[k], tgts[k], 0, 0, 1);
      checks++;
      if (pc16 !== want[k] || observed(0) !== expected(0)) begin
        failures++;
        $display("[TB] FAIL call_return step %0d: got %h want pc %h model %h", k, observed(0), want[k], expected(0));
      end
    end
    checks++;
    if (empty16 !== 1'b1) begin
      failures++;
      $display("[TB] FAIL call_return_empty: got %b want 1", empty16);
    end
  endtask

  task automatic test_overflow;
    logic [15:0] pc_before;
    drive(0, OP_JUMP, 16'h0010, 0, 0, 1);
    for (int k = 0; k < 8; k++) drive(0, OP_CALL, 32'h500 + k * 32'h10, 0, 0, 1);
    checks++;
    if (full16 !== 1'b1 || observed(0) !== expected(0)) begin
      failures++;
      $display("[TB] FAIL overflow_full: got %h want %h", observed(0), expected(0));
    end
    pc_before = pc16;
    drive(0, OP_CALL, 16'h0ABC, 0, 0, 1);
    checks++;
    if (pc16 !== pc_before || err16 !== 1'b1 || full16 !== 1'b1 || observed(0) !== expected(0)) begin
      failures++;
      $display("[TB] FAIL overflow_err: got %h want pc %h err 1 full 1", observed(0), pc_before);
    end
    drive(0, OP_HOLD, 0, 0, 0, 1);
    checks++;
    if (err16 !== 1'b0 || observed(0) !== expected(0)) begin
      failures++;
      $display("[TB] FAIL overflow_err_pulse: got %h want %h", observed(0), expected(0));
    end
    for (int k = 0; k < 8; k++) begin
      drive(0, OP_RETURN, 0, 0, 0, 1);
      checks++;
      if (observed(0) !== expected(0)) begin
        failures++;
        $display("[TB] FAIL overflow_unwind %0d: got %h want %h", k, observed(0), expected(0));
      end
    end
  endtask

  task automatic test_underflow_stall;
    logic [18:0] snap;
    drive(0, OP_JUMP, 16'h0777, 0, 0, 1);
    drive(0, OP_RETURN, 0, 0, 0, 1);
    checks++;
    if (pc16 !== 16'h0777 || err16 !== 1'b1 || observed(0) !== expected(0)) begin
      failures++;
      $display("[TB] FAIL underflow: got %h want %h", observed(0), expected(0));
    end
    drive(0, OP_HOLD, 0, 0, 0, 1);
    drive(0, OP_CALL, 16'h0900, 0, 0, 1);
    snap = observed(0);
    for (int k = 0; k < 3; k++) begin
      drive(0, OP_JUMP, 16'h1234, 0, 0, 0);
      checks++;
      if (observed(0) !== snap || observed(0) !== expected(0)) begin
        failures++;
        $display("[TB] FAIL stall %0d: got %h want %h", k, observed(0), snap);
      end
    end
  endtask

  task automatic test_reload_12;
    drive(1, OP_JUMP, 12'h345, 0, 0, 1);
    for (int k = 0; k < 3; k++) drive(1, OP_CALL, 12'h100 * (k + 1), 0, 0, 1);
    drive(1, OP_RELOAD, 0, 0, 0, 1);
    checks++;
    if (pc12 !== 12'h010 || empty12 !== 1'b1 || observed(1) !== expected(1)) begin
      failures++;
      $display("[TB] FAIL reload12: got %h want pc 010 empty 1", observed(1));
    end
    for (int k = 0; k < 3; k++) drive(1, OP_CALL, 12'h200 + k, 0, 0, 1);
    async_reset(1);
    checks++;
    if (pc12 !== 12'h010 || empty12 !== 1'b1 || err12 !== 1'b0) begin
      failures++;
      $display("[TB] FAIL midreset12: got %h want pc 010 empty 1", observed(1));
    end
    release_reset(1);
    drive(1, OP_JUMP, 12'hFFF, 0, 0, 1);
    drive(1, OP_INC, 0, 0, 0, 1);
    checks++;
    if (pc12 !== 12'h000 || observed(1) !== expected(1)) begin
      failures++;
      $display("[TB] FAIL inc_wrap12: got %h want pc 000", observed(1));
    end
    en12 = 1'b0;
  endtask

  task automatic test_random(int i, int cycles);
    logic [2:0]  op;
    int unsigned tgt, off;
    bit          c, en;
    for (int k = 0; k < cycles; k++) begin
      op = 3'($urandom_range(0, 7));
      if (op == OP_RELOAD && $urandom_range(0, 3) != 0) op = OP_CALL;
      tgt = $urandom;
      off = $urandom;
      c   = 1'($urandom_range(0, 1));
      en  = ($urandom_range(0, 7) != 0);
      drive(i, op, tgt, off, c, en);
      checks++;
      if (observed(i) !== expected(i)) begin
        failures++;
        $display("[TB] FAIL random%0d cycle %0d op %0d en %0b: got %h want %h", i, k, op, en, observed(i), expected(i));
      end
    end
    if (i == 0) en16 = 1'b0; else en12 = 1'b0;
  endtask

  initial begin
    rst16_n = 1'b0; en16 = 1'b0; op16 = OP_HOLD; tgt16 = '0; off16 = '0; cond16 = 1'b0;
    rst12_n = 1'b0; en12 = 1'b0; op12 = OP_HOLD; tgt12 = '0; off12 = '0; cond12 = 1'b0;
    model_reset(0);
    model_reset(1);
    #12;
    rst16_n = 1'b1;
    rst12_n = 1'b1;
    test_reset();
    test_inc_wrap();
    test_branch();
    test_call_return();
    test_overflow();
    test_underflow_stall();
    test_reload_12();
    test_random(0, 400);
    test_random(1, 200);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/program_counter_stack.md
# program_counter_stack

Parametrised program counter with a hardware return-address stack, successor to the fixed 16-bit, four-opcode counter. It generates the fetch address for the instruction memory each cycle. Supported operations are hold, increment, absolute jump, conditional relative branch, call/return and a vector reload, with a stall input and stack overflow/underflow reporting. It sits between the decode stage, which supplies the opcode and operands, and the instruction-memory address port.

## Interface
- ADDR_WIDTH, 16, width of the program counter and all address operands
- STACK_DEPTH, 8, number of return-address entries (power of two, ≥2)
- RESET_VECTOR, 0, value loaded into pc_out on reset and on opcode RELOAD
- clock  input  1  rising-edge system clock
- reset_n  input  1  asynchronous, active-low reset
- enable  input  1  1 = execute opcode this cycle; 0 = stall, everything holds
- opcode  input  3  operation select (encodings under Operation)
- target  input  ADDR_WIDTH  absolute address for JUMP and CALL
- offset  input  ADDR_WIDTH  two's-complement displacement for BRANCH
- cond  input  1  branch condition for BRANCH
- pc_out  output  ADDR_WIDTH  registered current program counter
- stack_empty  output  1  no return addresses held
- stack_full  output  1  STACK_DEPTH entries held
- stack_err  output  1  one-cycle pulse on rejected CALL (full) or RETURN (empty)

## Operation
- Opcodes: 000 HOLD, 001 INC, 010 JUMP, 011 BRANCH, 100 CALL, 101 RETURN, 110 RELOAD, 111 reserved (behaves as HOLD, no error).
- INC: pc_out ← pc_out + 1, modulo 2^ADDR_WIDTH. 0xFFFF wraps to 0x0000 at width 16.
- JUMP: pc_out ← target.
- BRANCH: cond=1 → pc_out ← pc_out + offset (mod 2^ADDR_WIDTH, no overflow flag); cond=0 → pc_out ← pc_out + 1.
- CALL, not full: push pc_out + 1 (wrapped), pc_out ← target.
- CALL, full: no push, pc_out holds, stack_err pulses.
- RETURN, not empty: pop the top entry, pc_out ← popped value.
- RETURN, empty: pc_out holds, stack_err pulses.
- RELOAD: pc_out ← RESET_VECTOR. Stack is flushed (pointer to 0). No error.
- enable=0: no state changes, regardless of opcode. stack_err=0.
- Stack is LIFO. The pointer counts 0..STACK_DEPTH.
- stack_empty = (ptr==0). stack_full = (ptr==STACK_DEPTH). Both are combinational from the registered pointer.
- Exactly one operation per cycle. CALL immediately followed by RETURN returns to the call address + 1.

## Timing
- Reset (asynchronous, reset_n=0): pc_out=RESET_VECTOR, ptr=0, stack_empty=1, stack_full=0, stack_err=0. Stack contents are don't-care.
- Reset has immediate effect, including mid-call-sequence. On deassertion, the first update happens at the next rising edge with reset_n=1.
- Latency is 1 cycle: inputs sampled at edge N determine pc_out and flags after edge N.
- stack_err is registered. It is high for exactly the cycle following the rejected operation's edge.
- The stack read for RETURN uses the current registered top, so there is no bubble. Back-to-back RETURNs pop successive entries.

## Structure
- Shared package/header program_counter_pkg: opcode localparams (OP_HOLD … OP_RELOAD) and the 3-bit opcode width constant. Decode uses the same package.
- Sub-module pc_return_stack (parametrised by ADDR_WIDTH, STACK_DEPTH):
  - register array and pointer;
  - push/pop/flush inputs;
  - top, empty and full outputs;
  - ignores push when full and pop when empty.
- Top level holds:
  - the next-PC mux and adders;
  - the pc_out register;
  - error generation.

## Test plan
- Reset/INC wrap (defaults): assert reset_n=0 at a non-edge time → pc_out=0x0000 immediately. Load 0xFFFE via JUMP, then 2× INC → 0xFFFF, then 0x0000.
- BRANCH: pc=0x0040, offset=0xFFF0, cond=1 → 0x0030. Same operands with cond=0 → 0x0041.
- CALL/RETURN nesting:
  - pc=0x0100, CALL 0x0200 → pc=0x0200.
  - CALL 0x0300 → pc=0x0300.
  - RETURN → pc=0x0201.
  - RETURN → pc=0x0101, stack_empty=1.
- Overflow: 8 CALLs → stack_full=1. A 9th CALL to 0x0ABC → pc unchanged, stack_err high for exactly one cycle, depth stays 8. Then 8 RETURNs unwind in LIFO order.
- Underflow and stall:
  - RETURN on empty stack → pc holds, stack_err pulse.
  - enable=0 with opcode JUMP 0x1234 for 3 cycles → pc and flags unchanged, no err.
- RELOAD and mid-operation reset (RESET_VECTOR=0x0010, ADDR_WIDTH=12):
  - with 3 entries stacked, RELOAD → pc=0x010, stack_empty=1;
  - repeat, but pulse reset_n low mid-cycle instead → same result asynchronously;
  - INC at pc=0xFFF → 0x000.
